// File: rtl/s2_fp_unit_if.sv
// s2 custom-instruction bus between an initiator and a responder.
// Contents: one request strobe with opcode and two operands, and the
// responder's result word, one-cycle done pulse and busy flag.
// The master modport is the initiator side (gain FSM or any other s2
// client). The slave modport is the responder side (s2_fp_unit).
interface s2_fp_unit_if;
  logic        s2_start;
  logic [2:0]  s2_n;
  logic [31:0] s2_dataa;
  logic [31:0] s2_datab;
  logic [31:0] s2_result;
  logic        s2_done;
  logic        s2_busy;

  modport master (
    output s2_start, s2_n, s2_dataa, s2_datab,
    input  s2_result, s2_done, s2_busy
  );

  modport slave (
    input  s2_start, s2_n, s2_dataa, s2_datab,
    output s2_result, s2_done, s2_busy
  );
endinterface

// File: rtl/s2_fp_unit.sv
// s2_fp_unit: multi-cycle single-precision floating-point responder.
// Operations:
//   FLOATIS  int32 -> float
//   FMULS    float x float
//   FIXSI    float -> int32
// All operations truncate toward zero. Latency is fixed: a start in
// cycle 0 produces done and a valid result in cycle 3.
// Ports:
//   CLK    clock
//   RESET  synchronous, active-high reset
//   s2     s2 bus, slave side:
//            start/n/dataa/datab  request
//            result/done/busy     response
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for s2_start; opcode and operands latched on start
// ST_S1   | unpack operands into sign / exponent / magnitude / class
// ST_S2   | normalize and pack; result register loaded at end of S2
// ST_DONE | s2_done high for one cycle, result valid; back to IDLE
module s2_fp_unit (
  input logic        CLK,
  input logic        RESET,
  s2_fp_unit_if.slave s2
);

  localparam logic [2:0] OP_FLOATIS = 3'b010;
  localparam logic [2:0] OP_FMULS   = 3'b100;
  localparam logic [2:0] OP_FIXSI   = 3'b001;

  typedef enum logic [1:0] {ST_IDLE, ST_S1, ST_S2, ST_DONE} state_t;

  state_t state_q, state_d;
  logic   latch_en;

  // Latched request
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;

  // S1 -> S2 raw value registers
  logic               raw_sign;
  logic signed [9:0]  raw_exp;
  logic [47:0]        raw_mag;
  logic               raw_nan, raw_inf, raw_zero;

  logic [31:0] result_q;

  // S1 combinational unpack
  logic               s1_sign;
  logic signed [9:0]  s1_exp;
  logic [47:0]        s1_mag;
  logic               s1_nan, s1_inf, s1_zero;

  logic [7:0]  a_exp, b_exp;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0] a_abs;

  // S2 combinational pack
  logic [31:0]       s2_pack;
  logic [4:0]        fl_pos;
  logic [31:0]       fl_norm;
  logic signed [9:0] mul_exp;
  logic [22:0]       mul_mant;
  logic [4:0]        fx_sh;
  logic [31:0]       fx_mag;
  logic [31:0]       fx_val;
  logic              unused_bits;

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s2.s2_start) begin
          state_d  = ST_S1;
          latch_en = 1'b1;
        end
      end
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // S1: unpack
  // ---------------------------------------------------------------
  assign a_exp  = a_q[30:23];
  assign b_exp  = b_q[30:23];
  assign a_nan  = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
  // Denormals are flushed: any exp=0 operand counts as zero.
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_abs  = a_q[31] ? (32'd0 - a_q) : a_q;

  always_comb begin
    s1_sign = 1'b0;
    s1_exp  = '0;
    s1_mag  = '0;
    s1_nan  = 1'b0;
    s1_inf  = 1'b0;
    s1_zero = 1'b0;
    case (op_q)
      OP_FLOATIS: begin
        s1_sign = a_q[31];
        s1_mag  = {16'd0, a_abs};
        s1_zero = (a_q == 32'd0);
      end
      OP_FMULS: begin
        s1_sign = a_q[31] ^ b_q[31];
        s1_exp  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
        s1_mag  = {24'd0, 1'b1, a_q[22:0]} * {24'd0, 1'b1, b_q[22:0]};
        s1_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf  = a_inf | b_inf;
        s1_zero = a_zero | b_zero;
      end
      OP_FIXSI: begin
        s1_sign = a_q[31];
        s1_exp  = $signed({2'b00, a_exp}) - 10'sd127;
        s1_mag  = {24'd0, 1'b1, a_q[22:0]};
        s1_nan  = a_nan;
        s1_inf  = a_inf;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // S2: normalize and pack
  // ---------------------------------------------------------------
  always_comb begin
    fl_pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (raw_mag[i]) fl_pos = i[4:0];
    end
  end

  // Leading one moves to bit 31; bits 30:8 are the truncated fraction.
  assign fl_norm = raw_mag[31:0] << (5'd31 - fl_pos);

  // Product of two 1.x mantissas lies in [1,4); bit 47 set means >= 2.
  assign mul_exp  = raw_exp + $signed({9'd0, raw_mag[47]});
  assign mul_mant = raw_mag[47] ? raw_mag[46:24] : raw_mag[45:23];

  // Integer value = mantissa * 2^(exp-150); only used for 0 <= raw_exp <= 30.
  assign fx_sh = raw_exp[4:0];
  always_comb begin
    fx_mag = '0;
    if (raw_exp >= 10'sd23) fx_mag = {8'd0, raw_mag[23:0]} << (fx_sh - 5'd23);
    else                    fx_mag = {8'd0, raw_mag[23:0]} >> (5'd23 - fx_sh);
  end
  assign fx_val = raw_sign ? (32'd0 - fx_mag) : fx_mag;

  always_comb begin
    s2_pack = 32'd0;
    case (op_q)
      OP_FLOATIS: begin
        if (!raw_zero) s2_pack = {raw_sign, 8'd127 + {3'd0, fl_pos}, fl_norm[30:8]};
      end
      OP_FMULS: begin
        if (raw_nan)                   s2_pack = 32'h7FC0_0000;
        else if (raw_inf)              s2_pack = {raw_sign, 8'hFF, 23'd0};
        else if (raw_zero)             s2_pack = {raw_sign, 31'd0};
        else if (mul_exp >= 10'sd255)  s2_pack = {raw_sign, 8'hFF, 23'd0};
        else if (mul_exp <= 10'sd0)    s2_pack = {raw_sign, 31'd0};
        else                           s2_pack = {raw_sign, mul_exp[7:0], mul_mant};
      end
      OP_FIXSI: begin
        if (raw_nan)                           s2_pack = 32'h7FFF_FFFF;
        else if (raw_inf || raw_exp >= 10'sd31) s2_pack = raw_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (raw_exp < 10'sd0)             s2_pack = 32'd0;
        else                                   s2_pack = fx_val;
      end
      default: s2_pack = 32'd0;
    endcase
  end

  assign unused_bits = ^{fl_norm[31], fl_norm[7:0]};

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      raw_sign <= 1'b0;
      raw_exp  <= '0;
      raw_mag  <= '0;
      raw_nan  <= 1'b0;
      raw_inf  <= 1'b0;
      raw_zero <= 1'b0;
      result_q <= '0;
    end else begin
      if (latch_en) begin
        op_q <= s2.s2_n;
        a_q  <= s2.s2_dataa;
        b_q  <= s2.s2_datab;
      end
      if (state_q == ST_S1) begin
        raw_sign <= s1_sign;
        raw_exp  <= s1_exp;
        raw_mag  <= s1_mag;
        raw_nan  <= s1_nan;
        raw_inf  <= s1_inf;
        raw_zero <= s1_zero;
      end
      // Loaded on the S2->DONE edge, so the new value is already on the
      // bus during the DONE cycle, and it holds until the next DONE.
      if (state_q == ST_S2) result_q <= s2_pack;
    end
  end

  assign s2.s2_result = result_q;
  assign s2.s2_done   = (state_q == ST_DONE);
  assign s2.s2_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s2_fp_unit.sv
// Self-checking bench for s2_fp_unit: table of directed vectors run
// back-to-back, plus gain chain, ignored-start and mid-op reset sequences.
module tb_s2_fp_unit;

  localparam logic [2:0] OP_FLOATIS = 3'b010;
  localparam logic [2:0] OP_FMULS   = 3'b100;
  localparam logic [2:0] OP_FIXSI   = 3'b001;

  typedef struct {
    logic [2:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  s2_fp_unit_if bus();

  s2_fp_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .s2    (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start in the current cycle (cycle 0), scramble operands from cycle 1,
  // and return in the done cycle with the latency in cycles.
  task automatic run_op(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1);
    bus.s2_n     = n;
    bus.s2_dataa = a;
    bus.s2_datab = b;
    bus.s2_start = 1'b1;
    tick();
    bus.s2_start = 1'b0;
    bus.s2_n     = ~n;
    bus.s2_dataa = ~a;
    bus.s2_datab = ~b;
    busy1 = bus.s2_busy;
    lat = 1;
    while (!bus.s2_done && lat < 10) begin
      tick();
      lat++;
    end
    res = bus.s2_result;
  endtask

  vec_t        vecs[20];
  logic [31:0] res;
  logic [31:0] chain;
  int          lat;
  logic        busy1;
  int          done_cnt;
  int          done_cyc;

  initial begin
    vecs[0]  = '{OP_FLOATIS, 32'h0000_0064, 32'h0, 32'h42C8_0000};
    vecs[1]  = '{OP_FLOATIS, 32'h0100_0001, 32'h0, 32'h4B80_0000};
    vecs[2]  = '{OP_FLOATIS, 32'h0000_0000, 32'h0, 32'h0000_0000};
    vecs[3]  = '{OP_FLOATIS, 32'h8000_0000, 32'h0, 32'hCF00_0000};
    vecs[4]  = '{OP_FMULS,   32'h42C8_0000, 32'h3F00_0000, 32'h4248_0000};
    vecs[5]  = '{OP_FMULS,   32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
    vecs[6]  = '{OP_FMULS,   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
    vecs[7]  = '{OP_FMULS,   32'h8000_0000, 32'h4000_0000, 32'h8000_0000};
    vecs[8]  = '{OP_FMULS,   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000};
    vecs[9]  = '{OP_FMULS,   32'h0080_0000, 32'h0080_0000, 32'h0000_0000};
    vecs[10] = '{OP_FMULS,   32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
    vecs[11] = '{OP_FMULS,   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    vecs[12] = '{OP_FIXSI,   32'h4248_0000, 32'h0, 32'h0000_0032};
    vecs[13] = '{OP_FIXSI,   32'h4F80_0000, 32'h0, 32'h7FFF_FFFF};
    vecs[14] = '{OP_FIXSI,   32'hCF80_0000, 32'h0, 32'h8000_0000};
    vecs[15] = '{OP_FIXSI,   32'h3F00_0000, 32'h0, 32'h0000_0000};
    vecs[16] = '{OP_FIXSI,   32'h7FC0_0000, 32'h0, 32'h7FFF_FFFF};
    vecs[17] = '{OP_FIXSI,   32'h4EFF_FFFF, 32'h0, 32'h7FFF_FF80};
    vecs[18] = '{OP_FIXSI,   32'h3F80_0000, 32'h0, 32'h0000_0001};
    vecs[19] = '{3'b111,     32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};

    bus.s2_start = 1'b0;
    bus.s2_n     = '0;
    bus.s2_dataa = '0;
    bus.s2_datab = '0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    check("reset_result", bus.s2_result, 32'h0);
    check("reset_done", {31'd0, bus.s2_done}, 32'd0);
    check("reset_busy", {31'd0, bus.s2_busy}, 32'd0);

    // Directed table, each op started in the first IDLE cycle after done.
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].n, vecs[i].a, vecs[i].b, res, lat, busy1);
      check($sformatf("vec%0d_busy_c1", i), {31'd0, busy1}, 32'd1);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      tick();
      check($sformatf("vec%0d_done_width", i), {31'd0, bus.s2_done}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), bus.s2_result, vecs[i].exp);
    end

    // Gain chain, back-to-back, result of each step feeds the next.
    run_op(OP_FLOATIS, 32'hFFFF_FFF9, 32'h0, chain, lat, busy1);
    check("chain_floatis", chain, 32'hC0E0_0000);
    check("chain_floatis_lat", lat, 32'd3);
    tick();
    check("chain_floatis_pulse", {31'd0, bus.s2_done}, 32'd0);
    run_op(OP_FMULS, chain, 32'h4000_0000, chain, lat, busy1);
    check("chain_fmuls", chain, 32'hC160_0000);
    check("chain_fmuls_lat", lat, 32'd3);
    tick();
    check("chain_fmuls_pulse", {31'd0, bus.s2_done}, 32'd0);
    run_op(OP_FIXSI, chain, 32'h0, chain, lat, busy1);
    check("chain_fixsi", chain, 32'hFFFF_FFF2);
    check("chain_fixsi_lat", lat, 32'd3);
    tick();
    check("chain_fixsi_pulse", {31'd0, bus.s2_done}, 32'd0);

    // Ignored start: start held high through cycles 1-3 with other operands.
    bus.s2_n     = OP_FLOATIS;
    bus.s2_dataa = 32'h0000_0064;
    bus.s2_datab = 32'h0;
    bus.s2_start = 1'b1;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 3) begin
        bus.s2_start = 1'b1;
        bus.s2_n     = OP_FMULS;
        bus.s2_dataa = 32'h4000_0000 + c;
        bus.s2_datab = 32'h4040_0000;
      end else begin
        bus.s2_start = 1'b0;
      end
      if (bus.s2_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = bus.s2_result;
        end
      end
    end
    check("ignored_done_count", done_cnt, 32'd1);
    check("ignored_done_cycle", done_cyc, 32'd3);
    check("ignored_result", res, 32'h42C8_0000);

    // Reset in cycle 2 of an FMULS aborts it.
    bus.s2_n     = OP_FMULS;
    bus.s2_dataa = 32'h42C8_0000;
    bus.s2_datab = 32'h3F00_0000;
    bus.s2_start = 1'b1;
    tick();
    bus.s2_start = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_result", bus.s2_result, 32'h0);
    check("abort_busy", {31'd0, bus.s2_busy}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.s2_done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 32'd0);

    run_op(OP_FMULS, 32'h42C8_0000, 32'h3F00_0000, res, lat, busy1);
    check("post_reset_result", res, 32'h4248_0000);
    check("post_reset_lat", lat, 32'd3);
    tick();

    run_op(3'b111, 32'h4248_0000, 32'h4000_0000, res, lat, busy1);
    check("undef_result", res, 32'h0);
    check("undef_lat", lat, 32'd3);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2_fp_unit.md
# s2_fp_unit

Multi-cycle single-precision floating-point responder on the s2 custom-instruction interface. It accepts one operation per start pulse and returns a 32-bit result with a one-cycle done pulse. Supported operations are int32→float, float×float and float→int32. It sits behind the gain FSM and any other s2 initiator, and serves as the arithmetic engine for the per-sample gain path.

## Interface
Parameters: none; the opcode encoding and latency are fixed.

Ports (name, direction, width, meaning):
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- s2_start  in  1  request strobe, sampled only in IDLE
- s2_n  in  3  opcode: 3'b010 FLOATIS, 3'b100 FMULS, 3'b001 FIXSI
- s2_dataa  in  32  operand A (int32 for FLOATIS; IEEE-754 single for FMULS and FIXSI)
- s2_datab  in  32  operand B (FMULS only; ignored otherwise)
- s2_result  out  32  registered result; valid while s2_done=1 and held until the next done
- s2_done  out  1  one-cycle completion pulse
- s2_busy  out  1  high while a request is in flight (S1, S2, DONE)

## Operation
- **FSM states:** IDLE → S1 → S2 → DONE → IDLE. All transitions are unconditional except IDLE→S1, which requires s2_start=1.
- **IDLE:**
  - On s2_start=1, latch s2_n, s2_dataa and s2_datab into internal registers.
  - Operands are not sampled after the start cycle.
- **S1:** unpack the operands and compute the raw value.
  - FLOATIS: sign and absolute value.
  - FMULS: sign XOR, biased exponent sum minus 127 (10-bit signed), and the 24×24 mantissa product (48-bit).
  - FIXSI: unbiased exponent and the 24-bit mantissa with the hidden 1.
- **S2:** normalize and pack into a result register.
  - FLOATIS: leading-one detect, left-align, exponent = 127 + position.
  - FMULS: if product bit 47 is set, shift right by 1 and increment the exponent.
  - FIXSI: shift the mantissa by (exp−150), then apply the sign by two's complement.
- **DONE:** drive s2_done=1 and load s2_result from the S2 result register. Return to IDLE.
- **Rounding:** truncation toward zero for all ops; no round-to-nearest.
- **FLOATIS special cases:**
  - 0 → 0x00000000.
  - 0x80000000 → 0xCF000000.
  - Magnitudes above 2^24 drop their low bits (truncation).
- **FMULS special cases:**
  - An operand with exp=0 (zero or denormal) is treated as zero.
  - Zero × finite → signed zero (sign = XOR of input signs).
  - NaN input, or inf × zero → 0x7FC00000.
  - inf × nonzero → ±inf (exp 255, mantissa 0).
  - Result exponent ≥ 255 → ±inf.
  - Result exponent ≤ 0 → signed zero.
- **FIXSI special cases:**
  - exp < 127 → 0.
  - Unbiased exp ≥ 31, or inf → 0x7FFFFFFF if positive, 0x80000000 if negative.
  - NaN → 0x7FFFFFFF.
- **Undefined opcode:** still completes in the normal latency with s2_result = 0x00000000.

## Timing
- **Reset values:** s2_result=0, s2_done=0, s2_busy=0, FSM in IDLE.
- **Reset mid-operation:** RESET in any state aborts the operation, returns to IDLE next cycle and clears all outputs. No done is issued for the aborted request.
- **Latency:** fixed. s2_start high in cycle 0 (IDLE) gives s2_done high in cycle 3, with s2_result valid in cycle 3.
- **Back-to-back:** minimum start-to-start spacing is 4 cycles. The earliest next start is cycle 4, the first IDLE cycle after DONE.
- **Ignored starts:** s2_start while busy (S1, S2, DONE) is ignored, with no queueing and no error.
- **Operand hold:** the initiator may change s2_dataa, s2_datab and s2_n from cycle 1 onward without affecting the result.
- **Result hold:** s2_result holds its value after done until the next DONE state. s2_done is never high for two consecutive cycles.

## Test plan
- **FLOATIS:** start with n=010, dataa=0x00000064 → done in cycle 3, result 0x42C80000. dataa=0x01000001 → 0x4B800000 (truncation).
- **FMULS:** 0x42C80000 × 0x3F000000 → 0x42480000. 0x7F000000 × 0x40000000 → 0x7F800000 (overflow). 0x7F800000 × 0x00000000 → 0x7FC00000.
- **FIXSI:** 0x42480000 → 0x00000032. 0x4F800000 → 0x7FFFFFFF. 0xCF800000 → 0x80000000. 0x3F000000 → 0x00000000.
- **Gain chain:** FLOATIS(0xFFFFFFF9) → 0xC0E00000; FMULS ×0x40000000 → 0xC1600000; FIXSI → 0xFFFFFFF2. Each step starts in the first IDLE cycle after the previous done, and each done lasts exactly one cycle.
- **Ignored start:** assert start in cycles 1–3 with different operands → exactly one done, in cycle 3, carrying the cycle-0 result.
- **Reset and undefined opcode:**
  - Assert RESET in cycle 2 of a FMULS → no done is issued, and result=0 and busy=0 after reset.
  - A fresh start afterwards completes normally.
  - n=3'b111 → done in cycle 3 with result 0x00000000.
